// File: rtl/instr_buffer.sv
// Fetch-to-decode {pc, instr} FIFO, DEPTH entries; 1-cycle latency (0 with INSTR_BUFFER_BYPASS_EN).
// Backpressure: fetch_ready_o drops while full; flush_i empties the queue at the next edge.
package riscv_pkg;
    parameter int XLEN = 32;
endpackage

module instr_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       fetch_valid_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    input  logic [31:0]                fetch_instr_i,
    output logic                       fetch_ready_o,
    output logic                       dec_valid_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [31:0]                dec_instr_o,
    input  logic                       dec_ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty;
    logic            push;
    logic            push_wr;
    logic            pop_mem;

    assign empty         = (count_q == '0);
    assign fetch_ready_o = (count_q != CNT_FULL);
    assign push          = fetch_valid_i & fetch_ready_o;
    assign pop_mem       = ~empty & dec_ready_i;
    assign count_o       = count_q;

`ifdef INSTR_BUFFER_BYPASS_EN
    logic bypass;
    // An empty queue forwards the fetch pair straight to decode; if decode takes it, nothing is stored.
    assign bypass      = empty & fetch_valid_i & ~flush_i;
    assign push_wr     = push & ~(bypass & dec_ready_i);
    assign dec_valid_o = ~empty | bypass;
    assign dec_pc_o    = bypass ? fetch_pc_i    : mem_q[rd_ptr_q].pc;
    assign dec_instr_o = bypass ? fetch_instr_i : mem_q[rd_ptr_q].instr;
`else
    assign push_wr     = push;
    assign dec_valid_o = ~empty;
    assign dec_pc_o    = mem_q[rd_ptr_q].pc;
    assign dec_instr_o = mem_q[rd_ptr_q].instr;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_mem) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_wr && !pop_mem) count_d = count_q + CNT_ONE;
            else if (!push_wr && pop_mem) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_wr && !flush_i) mem_q[wr_ptr_q] <= '{pc: fetch_pc_i, instr: fetch_instr_i};
        end
    end
endmodule

// File: tb/tb_instr_buffer.sv
// Directed table-driven bench for instr_buffer, plus hand-written reset and bypass sequences.
module tb_instr_buffer;
    logic        clk;
    logic        rstn;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;
    logic        flush;
    logic [2:0]  count;

`ifdef INSTR_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    instr_buffer #(.DEPTH(4)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .fetch_valid_i (fetch_valid),
        .fetch_pc_i    (fetch_pc),
        .fetch_instr_i (fetch_instr),
        .fetch_ready_o (fetch_ready),
        .dec_valid_o   (dec_valid),
        .dec_pc_o      (dec_pc),
        .dec_instr_o   (dec_instr),
        .dec_ready_i   (dec_ready),
        .flush_i       (flush),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        logic        ev;
        logic        chk_pc;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic        efr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [31:0] mk_ins(input logic [31:0] pc);
        return {pc[11:0], 20'h00013};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic add(input logic fv, input logic [31:0] pc, input logic dr, input logic fl,
                       input logic ev, input logic chk_pc, input logic [31:0] epc,
                       input logic [2:0] ecnt, input logic efr);
        vec_t v;
        v.fv = fv; v.pc = pc; v.dr = dr; v.fl = fl;
        v.ev = ev; v.chk_pc = chk_pc; v.epc = epc; v.ecnt = ecnt; v.efr = efr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic dr, input logic fl);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = mk_ins(pc);
        dec_ready   = dr;
        flush       = fl;
    endtask

    initial begin
        logic [31:0] head;
        rstn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_dec_pc", 64'(dec_pc), 64'd0);
        chk("rst_dec_instr", 64'(dec_instr), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        #4 rstn = 1'b1;

        // Single push, fill to full with an ignored 5th push, pop, then streaming across the wrap.
        add(1, 32'h8000_0000, 0, 0, BYP, BYP, 32'h8000_0000, 3'd0, 1);
        add(1, 32'h8000_0004, 0, 0, 1, 1, 32'h8000_0000, 3'd1, 1);
        add(1, 32'h8000_0008, 0, 0, 1, 1, 32'h8000_0000, 3'd2, 1);
        add(1, 32'h8000_000C, 0, 0, 1, 1, 32'h8000_0000, 3'd3, 1);
        add(1, 32'h8000_0010, 0, 0, 1, 1, 32'h8000_0000, 3'd4, 0);
        add(1, 32'h8000_0014, 1, 0, 1, 1, 32'h8000_0000, 3'd4, 0);
        add(0, 32'h0,         0, 0, 1, 1, 32'h8000_0004, 3'd3, 1);
        add(0, 32'h0,         1, 0, 1, 1, 32'h8000_0004, 3'd3, 1);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      head = 32'h8000_0008;
            else if (k == 1) head = 32'h8000_000C;
            else             head = 32'h8000_0020 + 32'(4 * (k - 2));
            add(1, 32'h8000_0020 + 32'(4 * k), 1, 0, 1, 1, head, 3'd2, 1);
        end
        add(1, 32'h8000_0050, 0, 0, 1, 1, 32'h8000_0040, 3'd2, 1);
        add(1, 32'h8000_0100, 0, 1, 1, 1, 32'h8000_0040, 3'd3, 1);
        add(1, 32'h8000_0200, 0, 0, BYP, BYP, 32'h8000_0200, 3'd0, 1);
        add(1, 32'h8000_0300, 0, 0, 1, 1, 32'h8000_0200, 3'd1, 1);
        add(0, 32'h0,         0, 0, 1, 1, 32'h8000_0200, 3'd2, 1);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].dr, vecs[i].fl);
            #2;
            chk($sformatf("vec%0d_dec_valid", i), 64'(dec_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ecnt));
            chk($sformatf("vec%0d_fetch_ready", i), 64'(fetch_ready), 64'(vecs[i].efr));
            if (vecs[i].chk_pc) begin
                chk($sformatf("vec%0d_dec_pc", i), 64'(dec_pc), 64'(vecs[i].epc));
                chk($sformatf("vec%0d_dec_instr", i), 64'(dec_instr), 64'(mk_ins(vecs[i].epc)));
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a cycle with two entries held.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk("async_rst_dec_pc", 64'(dec_pc), 64'd0);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Empty queue, push with decode ready: forwarded same cycle only when bypass is built in.
        drive(1'b1, 32'h8000_0040, 1'b1, 1'b0);
        #2;
        chk("bypass_dec_valid", 64'(dec_valid), 64'(BYP));
        if (BYP) chk("bypass_dec_pc", 64'(dec_pc), 64'h8000_0040);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bypass_next_count", 64'(count), BYP ? 64'd0 : 64'd1);
        chk("bypass_next_dec_valid", 64'(dec_valid), BYP ? 64'd0 : 64'd1);
        if (!BYP) chk("bypass_next_dec_pc", 64'(dec_pc), 64'h8000_0040);

        // Flush while empty with a valid fetch: nothing is forwarded or stored.
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h8000_0080, 1'b0, 1'b1);
        #1;
        chk("flush_empty_dec_valid", 64'(dec_valid), 64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("flush_empty_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
